// File: rtl/ft245_tx_arbiter.sv
`default_nettype none
// ft245_tx_arbiter: round-robin, packet-granular arbiter onto one FT245 TX byte port,
// with optional per-packet channel header byte and mid-packet starvation timeout. Rev 1.0
module ft245_tx_arbiter #(
  parameter int         N_CH           = 4,
  parameter bit         HDR_EN         = 1'b1,
  parameter logic [3:0] HDR_TAG        = 4'hA,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [8*N_CH-1:0] req_data,
  input  logic [N_CH-1:0]   req_valid,
  input  logic [N_CH-1:0]   req_last,
  output logic [N_CH-1:0]   req_ack,
  output logic [7:0]        tx_data_si,
  output logic              tx_rdy_si,
  input  logic              tx_ack_si,
  output logic              grant_valid,
  output logic [3:0]        grant_ch,
  output logic              timeout_err
);

  localparam bit              TO_EN   = (TIMEOUT_CYCLES > 0);
  localparam int              TW      = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0]   TLIM    = TW'(TIMEOUT_CYCLES);
  localparam logic [3:0]      LAST_CH = 4'(N_CH - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HDR     = 2'd1,
    PAYLOAD = 2'd2
  } state_t;

  state_t          state, state_nx;
  logic [3:0]      ptr, ptr_nx;
  logic [3:0]      grant_ch_nx;
  logic            grant_valid_nx;
  logic [7:0]      tx_data_nx;
  logic            tx_rdy_nx;
  logic [N_CH-1:0] req_ack_nx;
  logic            timeout_err_nx;
  logic            last_q, last_nx;
  logic [TW-1:0]   cnt, cnt_nx;

  logic            found;
  logic [3:0]      winner;
  logic [4:0]      idx;
  logic [N_CH-1:0] sel_mask;
  logic            g_valid;
  logic            g_last;
  logic [7:0]      g_data;
  logic [3:0]      ptr_after;

  // First valid requester at or after ptr, wrapping modulo N_CH.
  always_comb begin
    found  = 1'b0;
    winner = 4'd0;
    idx    = 5'd0;
    for (int k = 0; k < N_CH; k++) begin
      idx = {1'b0, ptr} + 5'(k);
      if (idx >= 5'(N_CH)) idx = idx - 5'(N_CH);
      if (!found && (|((req_valid >> idx) & N_CH'(1)))) begin
        found  = 1'b1;
        winner = idx[3:0];
      end
    end
  end

  assign sel_mask  = N_CH'(1) << grant_ch;
  assign g_valid   = |(req_valid & sel_mask);
  assign g_last    = |(req_last & sel_mask);
  assign g_data    = 8'(req_data >> {grant_ch, 3'b000});
  assign ptr_after = (grant_ch == LAST_CH) ? 4'd0 : grant_ch + 4'd1;

  always_comb begin
    state_nx       = state;
    ptr_nx         = ptr;
    grant_valid_nx = grant_valid;
    grant_ch_nx    = grant_ch;
    tx_data_nx     = tx_data_si;
    tx_rdy_nx      = tx_rdy_si;
    req_ack_nx     = '0;
    timeout_err_nx = 1'b0;
    last_nx        = last_q;
    cnt_nx         = cnt;

    if (tx_rdy_si && tx_ack_si) tx_rdy_nx = 1'b0;

    case (state)
      IDLE: begin
        if (found) begin
          grant_valid_nx = 1'b1;
          grant_ch_nx    = winner;
          last_nx        = 1'b0;
          cnt_nx         = '0;
          if (HDR_EN) begin
            tx_data_nx = {HDR_TAG, winner};
            tx_rdy_nx  = 1'b1;
            state_nx   = HDR;
          end else begin
            state_nx = PAYLOAD;
          end
        end
      end
      HDR: begin
        if (tx_rdy_si && tx_ack_si) state_nx = PAYLOAD;
      end
      PAYLOAD: begin
        // Loads happen only with the holding register empty, so ack and load never coincide.
        if (tx_rdy_si) begin
          if (tx_ack_si && last_q) begin
            grant_valid_nx = 1'b0;
            ptr_nx         = ptr_after;
            state_nx       = IDLE;
          end
        end else if (TO_EN && (cnt == TLIM)) begin
          timeout_err_nx = 1'b1;
          grant_valid_nx = 1'b0;
          ptr_nx         = ptr_after;
          cnt_nx         = '0;
          state_nx       = IDLE;
        end else if (g_valid) begin
          tx_data_nx = g_data;
          tx_rdy_nx  = 1'b1;
          req_ack_nx = sel_mask;
          last_nx    = g_last;
          cnt_nx     = '0;
        end else if (TO_EN) begin
          cnt_nx = cnt + TW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= 4'd0;
      grant_valid <= 1'b0;
      grant_ch    <= 4'd0;
      tx_data_si  <= 8'd0;
      tx_rdy_si   <= 1'b0;
      req_ack     <= '0;
      timeout_err <= 1'b0;
      last_q      <= 1'b0;
      cnt         <= '0;
    end else begin
      state       <= state_nx;
      ptr         <= ptr_nx;
      grant_valid <= grant_valid_nx;
      grant_ch    <= grant_ch_nx;
      tx_data_si  <= tx_data_nx;
      tx_rdy_si   <= tx_rdy_nx;
      req_ack     <= req_ack_nx;
      timeout_err <= timeout_err_nx;
      last_q      <= last_nx;
      cnt         <= cnt_nx;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ft245_tx_arbiter.sv
`default_nettype none
// tb_ft245_tx_arbiter: scoreboard bench; main instance HDR_EN=1/TIMEOUT_CYCLES=8,
// second instance HDR_EN=0 driven by hand.
module tb_ft245_tx_arbiter;
  localparam int N = 4;

  typedef struct packed {
    logic [3:0] ch;
    logic [7:0] data;
  } exp_t;

  logic          clk;
  logic          rst;
  logic [8*N-1:0] req_data;
  logic [N-1:0]  req_valid, req_last, req_ack;
  logic [7:0]    tx_data_si;
  logic          tx_rdy_si, tx_ack_si, grant_valid, timeout_err;
  logic [3:0]    grant_ch;

  logic [8*N-1:0] nh_req_data;
  logic [N-1:0]  nh_req_valid, nh_req_last, nh_req_ack;
  logic [7:0]    nh_tx_data;
  logic          nh_tx_rdy, nh_tx_ack, nh_grant_valid, nh_timeout_err;
  logic [3:0]    nh_grant_ch;

  int checks = 0;
  int errors = 0;
  int cyc;
  int to_cnt;
  int ack_cnt[N];
  int ack_delay = 4;
  logic [8:0] src_q[N][$];
  exp_t exp_q[$];

  ft245_tx_arbiter #(.N_CH(N), .HDR_EN(1'b1), .HDR_TAG(4'hA), .TIMEOUT_CYCLES(8)) u_dut (
    .clk(clk), .rst(rst), .req_data(req_data), .req_valid(req_valid), .req_last(req_last),
    .req_ack(req_ack), .tx_data_si(tx_data_si), .tx_rdy_si(tx_rdy_si), .tx_ack_si(tx_ack_si),
    .grant_valid(grant_valid), .grant_ch(grant_ch), .timeout_err(timeout_err));

  ft245_tx_arbiter #(.N_CH(N), .HDR_EN(1'b0), .HDR_TAG(4'hA), .TIMEOUT_CYCLES(0)) u_dut_nh (
    .clk(clk), .rst(rst), .req_data(nh_req_data), .req_valid(nh_req_valid), .req_last(nh_req_last),
    .req_ack(nh_req_ack), .tx_data_si(nh_tx_data), .tx_rdy_si(nh_tx_rdy), .tx_ack_si(nh_tx_ack),
    .grant_valid(nh_grant_valid), .grant_ch(nh_grant_ch), .timeout_err(nh_timeout_err));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  // Per-channel byte sources: pop on req_ack, present the queue head.
  initial begin
    logic [8:0] e;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (req_ack[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        if (src_q[i].size() > 0) begin
          e = src_q[i][0];
          req_valid[i]       = 1'b1;
          req_last[i]        = e[8];
          req_data[8*i +: 8] = e[7:0];
        end else begin
          req_valid[i] = 1'b0;
          req_last[i]  = 1'b0;
        end
      end
    end
  end

  // FT245 consumer: acks ack_delay cycles after tx_rdy_si, checks byte against the scoreboard.
  initial begin
    int wait_cnt;
    logic [7:0] held;
    exp_t e;
    tx_ack_si = 1'b0;
    wait_cnt  = 0;
    held      = 8'd0;
    forever begin
      @(posedge clk); #1;
      tx_ack_si = 1'b0;
      if (rst || !tx_rdy_si) begin
        wait_cnt = 0;
      end else begin
        if (wait_cnt == 0) begin
          held = tx_data_si;
        end else begin
          checks++;
          if (tx_data_si !== held) begin
            errors++;
            $display("FAIL tx_hold: tx_data_si=%02h changed while tx_rdy_si=1, required %02h", tx_data_si, held);
          end
        end
        wait_cnt++;
        if (wait_cnt >= ack_delay) begin
          tx_ack_si = 1'b1;
          wait_cnt  = 0;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL tx_unexpected: got byte %02h, required no byte", tx_data_si);
          end else begin
            e = exp_q.pop_front();
            if (tx_data_si !== e.data || grant_valid !== 1'b1 || grant_ch !== e.ch) begin
              errors++;
              $display("FAIL tx_byte: got data=%02h gv=%0b ch=%0d, required data=%02h gv=1 ch=%0d",
                       tx_data_si, grant_valid, grant_ch, e.data, e.ch);
            end
          end
        end
      end
    end
  end

  // Event counters and req_ack legality.
  initial begin
    cyc    = 0;
    to_cnt = 0;
    for (int i = 0; i < N; i++) ack_cnt[i] = 0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (timeout_err) to_cnt++;
      for (int i = 0; i < N; i++) if (req_ack[i]) ack_cnt[i]++;
      if (req_ack != '0) begin
        checks++;
        if (req_ack !== (4'b0001 << grant_ch)) begin
          errors++;
          $display("FAIL req_ack_onehot: req_ack=%b grant_ch=%0d, required single bit for granted channel",
                   req_ack, grant_ch);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  function automatic bit src_empty();
    for (int i = 0; i < N; i++) if (src_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic clear_queues();
    exp_q.delete();
    for (int i = 0; i < N; i++) src_q[i].delete();
  endtask

  task automatic send_pkt(input int ch, input int len, input logic [7:0] base,
                          input logic [7:0] step, input bit term);
    exp_t e;
    logic [7:0] d;
    e.ch   = 4'(ch);
    e.data = {4'hA, 4'(ch)};
    exp_q.push_back(e);
    for (int b = 0; b < len; b++) begin
      d = base + 8'(b) * step;
      src_q[ch].push_back({(term && b == len - 1), d});
      e.data = d;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && src_empty() && !grant_valid && !tx_rdy_si) && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s_drain: %0d bytes outstanding after %0d cycles, required 0", name, exp_q.size(), n);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    clear_queues();
    repeat (3) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if ({req_ack, tx_data_si, tx_rdy_si, grant_valid, grant_ch, timeout_err} !== '0) begin
      errors++;
      $display("FAIL reset_main: ack=%b data=%02h rdy=%0b gv=%0b ch=%0d to=%0b, required all 0",
               req_ack, tx_data_si, tx_rdy_si, grant_valid, grant_ch, timeout_err);
    end
    checks++;
    if ({nh_req_ack, nh_tx_data, nh_tx_rdy, nh_grant_valid, nh_grant_ch, nh_timeout_err} !== '0) begin
      errors++;
      $display("FAIL reset_nh: ack=%b data=%02h rdy=%0b gv=%0b, required all 0",
               nh_req_ack, nh_tx_data, nh_tx_rdy, nh_grant_valid);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    int a0;
    a0 = ack_cnt[1];
    send_pkt(1, 3, 8'h11, 8'h11, 1'b1);
    wait_drain(200, "single");
    checks++;
    if (ack_cnt[1] - a0 != 3) begin
      errors++;
      $display("FAIL single_acks: req_ack[1] pulses=%0d, required 3", ack_cnt[1] - a0);
    end
  endtask

  task automatic test_ptr_advance();
    send_pkt(2, 1, 8'h44, 8'h00, 1'b1);
    send_pkt(0, 1, 8'h40, 8'h00, 1'b1);
    wait_drain(200, "ptr_advance");
  endtask

  task automatic test_round_robin();
    int a[N];
    apply_reset();
    for (int i = 0; i < N; i++) a[i] = ack_cnt[i];
    for (int p = 0; p < 2; p++)
      for (int c = 0; c < N; c++)
        send_pkt(c, 2, 8'(16 * c + 4 * p), 8'h01, 1'b1);
    wait_drain(600, "round_robin");
    for (int i = 0; i < N; i++) begin
      checks++;
      if (ack_cnt[i] - a[i] != 4) begin
        errors++;
        $display("FAIL rr_acks: ch%0d req_ack pulses=%0d, required 4", i, ack_cnt[i] - a[i]);
      end
    end
  endtask

  task automatic test_timeout();
    int a0, t0, t1, n;
    a0 = ack_cnt[0];
    t0 = to_cnt;
    send_pkt(0, 1, 8'h01, 8'h00, 1'b0);
    send_pkt(1, 1, 8'h77, 8'h00, 1'b1);
    n = 0;
    while (ack_cnt[0] == a0 && n < 100) begin tick(); n++; end
    while (tx_rdy_si && n < 100) begin tick(); n++; end
    t1 = cyc;
    while (to_cnt == t0 && n < 100) begin tick(); n++; end
    checks++;
    if (cyc - t1 != 9 || n >= 100) begin
      errors++;
      $display("FAIL timeout_latency: timeout_err after %0d cycles of starvation, required 9", cyc - t1);
    end
    wait_drain(200, "timeout");
    checks++;
    if (to_cnt - t0 != 1) begin
      errors++;
      $display("FAIL timeout_pulses: timeout_err pulses=%0d, required 1", to_cnt - t0);
    end
    checks++;
    if (ack_cnt[0] - a0 != 1) begin
      errors++;
      $display("FAIL timeout_acks: req_ack[0] pulses=%0d, required 1", ack_cnt[0] - a0);
    end
  endtask

  task automatic test_backpressure();
    int t0;
    t0 = to_cnt;
    ack_delay = 100;
    send_pkt(2, 2, 8'hC0, 8'h01, 1'b1);
    wait_drain(800, "backpressure");
    ack_delay = 4;
    checks++;
    if (to_cnt != t0) begin
      errors++;
      $display("FAIL backpressure_timeout: timeout_err pulses=%0d, required 0", to_cnt - t0);
    end
  endtask

  task automatic test_reset_mid();
    int a3, n;
    a3 = ack_cnt[3];
    send_pkt(3, 3, 8'hD0, 8'h01, 1'b1);
    n = 0;
    while (ack_cnt[3] == a3 && n < 100) begin tick(); n++; end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL reset_mid_start: req_ack[3] pulses=0, required 1 before reset");
    end
    rst = 1'b1;
    clear_queues();
    tick();
    checks++;
    if ({req_ack, tx_data_si, tx_rdy_si, grant_valid, grant_ch, timeout_err} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: ack=%b data=%02h rdy=%0b gv=%0b ch=%0d to=%0b, required all 0",
               req_ack, tx_data_si, tx_rdy_si, grant_valid, grant_ch, timeout_err);
    end
    rst = 1'b0;
    send_pkt(0, 1, 8'hF0, 8'h00, 1'b1);
    send_pkt(3, 1, 8'hE0, 8'h00, 1'b1);
    wait_drain(200, "reset_mid");
  endtask

  task automatic test_no_header();
    int n;
    nh_req_data  = 32'h0055_0000;
    nh_req_valid = 4'b0100;
    nh_req_last  = 4'b0100;
    n = 0;
    while (!nh_tx_rdy && n < 20) begin tick(); n++; end
    checks++;
    if (nh_tx_data !== 8'h55 || nh_req_ack !== 4'b0100 || n >= 20) begin
      errors++;
      $display("FAIL nohdr_first_byte: data=%02h ack=%b, required data=55 ack=0100", nh_tx_data, nh_req_ack);
    end
    nh_req_valid = 4'b0000;
    nh_req_last  = 4'b0000;
    checks++;
    if (nh_grant_valid !== 1'b1 || nh_grant_ch !== 4'd2) begin
      errors++;
      $display("FAIL nohdr_grant: gv=%0b ch=%0d, required gv=1 ch=2", nh_grant_valid, nh_grant_ch);
    end
    tick();
    nh_tx_ack = 1'b1;
    tick();
    nh_tx_ack = 1'b0;
    checks++;
    if (nh_grant_valid !== 1'b0 || nh_tx_rdy !== 1'b0) begin
      errors++;
      $display("FAIL nohdr_release: gv=%0b rdy=%0b one cycle after ack, required 0 0", nh_grant_valid, nh_tx_rdy);
    end
    repeat (5) tick();
    checks++;
    if (nh_tx_rdy !== 1'b0 || nh_req_ack !== 4'b0000) begin
      errors++;
      $display("FAIL nohdr_extra: rdy=%0b ack=%b, required no further bytes", nh_tx_rdy, nh_req_ack);
    end
  endtask

  initial begin
    rst          = 1'b1;
    nh_req_data  = '0;
    nh_req_valid = '0;
    nh_req_last  = '0;
    nh_tx_ack    = 1'b0;
    test_reset();
    test_single();
    test_ptr_advance();
    test_round_robin();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    test_no_header();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ft245_tx_arbiter.md
Name: ft245_tx_arbiter

Overview:
- Round-robin, packet-granular arbiter that shares the single FT245 simple TX interface among N_CH byte-stream requesters.
- Optionally prefixes each packet with a channel header byte so host software can demultiplex streams.
- Guards against a stalled requester holding the link with a mid-packet timeout.
- Sits between the DSP/control stream sources and the FT245 FIFO interface's tx_data_si / tx_rdy_si / tx_ack_si port.

Parameters:
- N_CH, 4: number of requesters, 1..16.
- HDR_EN, 1: 1 = emit header byte {HDR_TAG[3:0], ch[3:0]} before each packet's payload.
- HDR_TAG, 4'hA: upper nibble of the header byte.
- TIMEOUT_CYCLES, 1024: mid-packet starvation limit in clk cycles; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- req_data  in  8*N_CH  byte from channel i on bits [8i+7:8i]
- req_valid  in  N_CH  channel i byte available
- req_last  in  N_CH  channel i byte is the last byte of its packet
- req_ack  out  N_CH  one-cycle pulse: channel i byte taken; the source presents its next byte or drops valid on the following cycle
- tx_data_si  out  8  byte to the FT245 interface
- tx_rdy_si  out  1  tx_data_si valid; held until acknowledged
- tx_ack_si  in  1  one-cycle pulse from the FT245 interface: byte consumed
- grant_valid  out  1  a packet is in progress
- grant_ch  out  4  granted channel index, valid while grant_valid=1
- timeout_err  out  1  one-cycle pulse on packet abort

Behaviour:
- Reset values: all outputs 0 (req_ack=0, tx_data_si=0, tx_rdy_si=0, grant_valid=0, grant_ch=0, timeout_err=0); state IDLE; rr pointer ptr=0; timeout counter 0.
- Reset mid-packet aborts immediately, with no req_ack or timeout_err pulse.
- All outputs are registered.
- Output holding register: tx_rdy_si is set when a byte is loaded. It is cleared on the clk edge where tx_ack_si=1 and tx_rdy_si=1. tx_ack_si while tx_rdy_si=0 is ignored.
- Bytes are loaded only when tx_rdy_si=0, so a load and an ack never coincide. This gives a minimum one-cycle bubble between bytes.
- IDLE:
  - Search channels ptr, ptr+1, ... wrapping modulo N_CH; the first with req_valid=1 wins.
  - Next edge: grant_valid=1, grant_ch=winner.
  - If HDR_EN: load header byte {HDR_TAG, winner}, tx_rdy_si=1, go to HDR.
  - Else: go to PAYLOAD without loading.
  - No valid requesters: stay in IDLE.
- HDR: on the header's ack, go to PAYLOAD.
- PAYLOAD:
  - If tx_rdy_si=0 and req_valid[g]=1: load req_data[g], tx_rdy_si=1, pulse req_ack[g] on that same edge, latch last_q=req_last[g], clear the timeout counter.
  - On an ack with last_q=1: grant_valid=0, ptr=(g+1) mod N_CH, go to IDLE.
  - The next arbitration starts in the following IDLE cycle.
- Timeout:
  - In PAYLOAD with tx_rdy_si=0 and req_valid[g]=0, the counter increments.
  - When the counter reaches TIMEOUT_CYCLES (non-zero), on the next edge: pulse timeout_err, grant_valid=0, ptr=(g+1) mod N_CH, go to IDLE, clear the counter.
  - No further bytes are taken from g for that packet.
  - The counter does not run in HDR or while tx_rdy_si=1, since FT245 backpressure is not starvation.
- Single-byte packet (req_last=1 on the first byte): header + 1 byte, then IDLE.
- Only req_valid of the granted channel matters in PAYLOAD; other channels' valid and last inputs are ignored and never acked.
- req_ack is one-hot or zero every cycle.

Test Plan:
- Single channel 1: 3-byte packet 0x11,0x22,0x33 (last on 0x33), FT245 model acks 4 cycles after tx_rdy_si -> tx stream 0xA1,0x11,0x22,0x33; req_ack[1] pulses exactly 3 times; grant_ch=1 throughout; ptr=2 afterwards.
- All 4 channels valid continuously with 2-byte packets -> header order 0xA0,0xA1,0xA2,0xA3,0xA0; no packet interleaving.
- HDR_EN=0, channel 2 packet 0x55 (last) -> only 0x55 sent; grant_valid low 1 cycle after its ack.
- Channel 0 drops req_valid mid-packet after 1 byte, TIMEOUT_CYCLES=8 -> timeout_err pulses once ~8 cycles later; grant moves to channel 1 if valid; no further req_ack[0] for that packet.
- FT245 holds off acks for 100 cycles with TIMEOUT_CYCLES=8 -> no timeout; tx_data_si stable while tx_rdy_si=1.
- Assert rst during channel 3 payload -> next edge all outputs 0; the following packet from channel 0 starts with header 0xA0 (ptr reset to 0).
